// File: rtl/seq_gen_pkg.sv
// seq_gen shared types and constants.
// State encoding and default run length for the serial frame generator.
package seq_gen_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int unsigned RUN_LEN_DEFAULT = 4;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/run_tracker.sv
// run_tracker: counts equal consecutive valid bits on the serial stream.
// run_flag_o is registered alongside the bit it describes.
module run_tracker
    import seq_gen_pkg::*;
#(
    parameter int unsigned RUN_LEN = RUN_LEN_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic bit_i,
    input  logic valid_i,
    output logic run_flag_o
);

    localparam int unsigned CW = cnt_width(RUN_LEN);
    localparam logic [CW-1:0] RUN_MAX = CW'(RUN_LEN);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          prev_q;
    logic          flag_q;
    logic          flag_d;

    // Next run count: extend on a repeated bit, restart on a change or gap.
    always_comb begin
        cnt_d  = '0;
        flag_d = 1'b0;
        if (valid_i) begin
            if ((cnt_q != '0) && (bit_i == prev_q)) begin
                cnt_d = (cnt_q == RUN_MAX) ? cnt_q : cnt_q + ONE;
            end else begin
                cnt_d = ONE;
            end
            flag_d = (cnt_d == RUN_MAX);
        end
    end

    // Run history registers; cleared by reset or any non-valid cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            prev_q <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            prev_q <= valid_i ? bit_i : 1'b0;
            flag_q <= flag_d;
        end
    end

    assign run_flag_o = flag_q;

endmodule

// File: rtl/seq_gen.sv
// seq_gen: loads a WIDTH-bit frame and shifts it out MSB first.
// Back-to-back frames are accepted in the last-bit cycle with no gap.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned RUN_LEN = RUN_LEN_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             out,
    output logic             out_valid,
    output logic             run_flag,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE = CW'(1);

    state_e           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [CW-1:0]    cnt_q;
    logic             out_q;
    logic             valid_q;
    logic             done_q;
    logic             ready_q;

    logic             last;
    logic             accept;
    logic             busy;
    logic             bit_d;
    logic             valid_d;
    logic [CW-1:0]    cnt_inc;

    // ready_q is high exactly in IDLE or the last-bit cycle, so it gates loads.
    always_comb begin
        last    = (state_q == SHIFT) && (cnt_q == LAST);
        accept  = load && ready_q;
        busy    = (state_q == SHIFT) && !last;
        valid_d = accept || busy;
        cnt_inc = cnt_q + ONE;
        bit_d   = 1'b0;
        if (accept) begin
            bit_d = data[WIDTH-1];
        end else if (busy) begin
            bit_d = sreg_q[WIDTH-1];
        end
    end

    // Frame FSM with shift register, bit counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            out_q   <= bit_d;
            valid_q <= valid_d;
            if (accept) begin
                state_q <= SHIFT;
                sreg_q  <= {data[WIDTH-2:0], 1'b0};
                cnt_q   <= '0;
                done_q  <= 1'b0;
                ready_q <= 1'b0;
            end else if (busy) begin
                state_q <= SHIFT;
                sreg_q  <= sreg_q << 1;
                cnt_q   <= cnt_inc;
                done_q  <= (cnt_inc == LAST);
                ready_q <= (cnt_inc == LAST);
            end else if (last) begin
                state_q <= IDLE;
                sreg_q  <= '0;
                cnt_q   <= '0;
                done_q  <= 1'b0;
                ready_q <= 1'b1;
            end
        end
    end

    run_tracker #(
        .RUN_LEN(RUN_LEN)
    ) u_run (
        .clk_i     (clk),
        .rst_i     (reset),
        .bit_i     (bit_d),
        .valid_i   (valid_d),
        .run_flag_o(run_flag)
    );

    assign ready     = ready_q;
    assign out       = out_q;
    assign out_valid = valid_q;
    assign done      = done_q;

endmodule
